mem_sp_ctrl: RTL
================

// Module: mem_sp_ctrl
// PURPOSE
//  Parametrised single-port synchronous RAM with request/response handshake; successor to the
//  fixed 12-bit/64-word store. Adds a post-reset clear sequence, address range checking and
//  1-cycle registered read responses. Sits between the CPU load/store stage and on-chip storage.
// PARAMETERS
//  DATA_W  12  word width in bits
//  ADDR_W  12  request address width
//  DEPTH   64  number of words (1 <= DEPTH <= 2**ADDR_W)
// PORTS
//  clk        in   1       single clock; all logic on posedge
//  rst        in   1       reset, synchronous, active-high
//  req_valid  in   1       request present
//  req_ready  out  1       block accepts a request this cycle
//  req_we     in   1       1 = write, 0 = read
//  req_addr   in   ADDR_W  word address
//  req_wdata  in   DATA_W  write data
//  dbg_flip   in   1       inverts the stored parity bit on a write; ignored without PARITY_EN
//  rsp_valid  out  1       read data valid (1-cycle pulse)
//  rsp_rdata  out  DATA_W  read data, registered
//  rsp_err    out  1       error flag qualified by rsp_valid
//  init_done  out  1       clear sequence finished
// BEHAVIOUR
//  - Reset: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, init_done=0; FSM -> S_INIT, clr_ptr=0.
//  - S_INIT: writes 0 (with correct parity) to word clr_ptr each cycle; clr_ptr++. After writing
//    word DEPTH-1 -> S_RUN; init_done=1 and req_ready=1 from the next cycle (DEPTH cycles after rst drops).
//  - rst asserted in any state, including mid-S_INIT, restarts the clear at word 0.
//  - S_RUN: req_ready=1 every cycle; accept = req_valid & req_ready. One op per cycle.
//  - Write accept: ram[req_addr] <= req_wdata at that edge; no response generated.
//  - Read accept: rsp_valid=1 exactly one cycle later, rsp_rdata=ram[addr] at acceptance.
//  - Read accepted the cycle after a write to the same address returns the new data.
//  - rsp_valid deasserts the cycle after its pulse unless another read is accepted; rsp_rdata
//    holds its last value between reads. No response backpressure.
//  - Address >= DEPTH: write dropped; read responds rsp_rdata=0, rsp_err=1.
//  - req_* ignored while req_ready=0; no request is queued.
// CONFIGURATION
//  PARITY_EN defined: each word stores DATA_W+1 bits (even parity over data). dbg_flip=1 on a write
//    stores the inverted parity bit. Read parity mismatch -> rsp_err=1, data returned unchanged.
//  PARITY_EN undefined: no parity bit stored; dbg_flip unused; rsp_err set only by out-of-range reads.
// STRUCTURE
//  mem_pkg: state enum {S_INIT, S_RUN}; function parity(); localparam for stored word width.
//  Sub-module mem_sp_array: storage only (sync write, registered read address, combinational
//    data out). mem_sp_ctrl holds the FSM, clear counter, range check and parity logic.
// TESTING
//  1. rst for 2 cycles then release -> init_done=0, req_ready=0 for 64 cycles, both 1 at cycle 65;
//     reading 0..63 all return 0x000, rsp_err=0.
//  2. write 0xABC @5, read @5 next cycle -> rsp_valid one cycle after accept, rsp_rdata=0xABC.
//  3. back-to-back reads @1,@2,@3 (preloaded 0x111/0x222/0x333) -> 3 consecutive rsp_valid
//     pulses, data in order.
//  4. read @64 and @0xFFF -> rsp_rdata=0x000, rsp_err=1; write 0x555 @64 then read @0 -> 0x000.
//  5. rst pulsed at clear cycle 30 after writing 0x777 @40 before it -> clear restarts, init_done
//     after 64 further cycles, @40 reads 0x000.
//  6. PARITY_EN: write 0x0F0 @7 with dbg_flip=1, read @7 -> rsp_rdata=0x0F0, rsp_err=1;
//     rewrite with dbg_flip=0 -> rsp_err=0. Without macro: same sequence -> rsp_err=0.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and helpers for the single-port RAM controller.
// Optional feature macro: PARITY_EN (adds one even-parity bit per stored word).
package mem_pkg;

    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

`ifdef PARITY_EN
    localparam int PAR_W = 1;
`else
    localparam int PAR_W = 0;
`endif

    // Width of one stored word for a given data width.
    function automatic int stored_w(input int data_w);
        return data_w + PAR_W;
    endfunction

    // Even parity bit: makes the XOR of data and parity bit zero.
    // Callers zero-extend narrower data into the 64-bit argument.
    function automatic logic parity(input logic [63:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/mem_sp_array.sv
// Storage array: synchronous write, registered read address, combinational data out.
// Word width already includes the parity bit when PARITY_EN is defined.
module mem_sp_array #(
    parameter int WORD_W = 12,
    parameter int DEPTH  = 64,
    parameter int IDX_W  = 6
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic              re,
    input  logic [IDX_W-1:0]  raddr,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH];
    logic [IDX_W-1:0]  raddr_q;

    // Write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Capture the read address; data follows combinationally from it.
    always_ff @(posedge clk) begin
        if (re) begin
            raddr_q <= raddr;
        end
    end

    assign rdata = mem[raddr_q];

endmodule

// File: rtl/mem_sp_ctrl.sv
// Single-port RAM controller: post-reset clear, range check, 1-cycle read response.
// Optional feature macro: PARITY_EN (even parity per word, dbg_flip corrupts it on write).
//
//  state  | meaning
//  S_INIT | clearing word clr_ptr each cycle, requests refused
//  S_RUN  | accepting one read or write per cycle
module mem_sp_ctrl
    import mem_pkg::*;
#(
    parameter int DATA_W = 12,
    parameter int ADDR_W = 12,
    parameter int DEPTH  = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic              dbg_flip,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              init_done
);

    localparam int WORD_W = stored_w(DATA_W);
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  clr_ptr_q, clr_ptr_d;
    logic              accept, rd_accept, in_range;
    logic              arr_we;
    logic [IDX_W-1:0]  arr_waddr;
    logic [WORD_W-1:0] arr_wdata, arr_rdata, wr_word;
    logic              rsp_valid_q, oor_q, par_err;
    logic [DATA_W-1:0] live_data, hold_q;

    assign req_ready = (state_q == S_RUN);
    assign init_done = (state_q == S_RUN);
    assign accept    = req_valid & req_ready;
    assign rd_accept = accept & ~req_we;
    // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
    assign in_range  = ({1'b0, req_addr} < (ADDR_W + 1)'(DEPTH));

`ifdef PARITY_EN
    logic [63:0] wdata_ext;

    // Zero-extend write data for the package parity helper.
    always_comb begin
        wdata_ext = '0;
        wdata_ext[DATA_W-1:0] = req_wdata;
    end

    assign wr_word = {parity(wdata_ext) ^ dbg_flip, req_wdata};
    assign par_err = ^arr_rdata;
`else
    logic unused_dbg_flip;
    assign unused_dbg_flip = dbg_flip;
    assign wr_word = req_wdata;
    assign par_err = 1'b0;
`endif

    // State register and clear pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_INIT;
            clr_ptr_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end

    // Next state and array write control; the clear writes all-zero words,
    // which already carry correct even parity.
    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        arr_we    = 1'b0;
        arr_waddr = req_addr[IDX_W-1:0];
        arr_wdata = wr_word;
        case (state_q)
            S_INIT: begin
                arr_we    = 1'b1;
                arr_waddr = clr_ptr_q;
                arr_wdata = '0;
                clr_ptr_d = clr_ptr_q + 1'b1;
                if (clr_ptr_q == LAST_IDX) begin
                    state_d   = S_RUN;
                    clr_ptr_d = '0;
                end
            end
            S_RUN: begin
                arr_we = accept & req_we & in_range;
            end
            default: begin
                state_d = S_INIT;
            end
        endcase
    end

    mem_sp_array #(
        .WORD_W (WORD_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk    (clk),
        .we     (arr_we),
        .waddr  (arr_waddr),
        .wdata  (arr_wdata),
        .re     (rd_accept & in_range),
        .raddr  (req_addr[IDX_W-1:0]),
        .rdata  (arr_rdata)
    );

    assign live_data = oor_q ? '0 : arr_rdata[DATA_W-1:0];

    // Response pulse, range flag and hold register; the hold keeps rsp_rdata
    // stable even if the addressed word is rewritten after the read.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            oor_q       <= 1'b0;
            hold_q      <= '0;
        end else begin
            rsp_valid_q <= rd_accept;
            if (rd_accept) begin
                oor_q <= ~in_range;
            end
            if (rsp_valid_q) begin
                hold_q <= live_data;
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_valid_q ? live_data : hold_q;
    assign rsp_err   = rsp_valid_q & (oor_q | par_err);

endmodule
